// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, ALU operation classes, nop word and the control word layout.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

   typedef struct packed {
      logic       reg_dst;
      logic       alu_src;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic       branch;
      logic       jump;
      logic [1:0] alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/id_decode_stage_if.sv
// Fetch-side, hazard-side and decoded-output signals of the IF/ID stage.
interface id_decode_stage_if;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc4;
   logic        stall_in;
   logic        flush;
   logic        ex_mem_read;
   logic [4:0]  ex_rt;

   logic        if_stall;
   logic        id_valid;
   logic [31:0] id_pc4;
   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic [15:0] imm16;
   logic [25:0] jaddr;
   logic        reg_dst;
   logic        alu_src;
   logic        mem_read;
   logic        mem_write;
   logic        mem_to_reg;
   logic        reg_write;
   logic        branch;
   logic        jump;
   logic [1:0]  alu_op;
   logic        id_illegal;

   modport master (
      output if_valid, if_instr, if_pc4, stall_in, flush, ex_mem_read, ex_rt,
      input  if_stall, id_valid, id_pc4, opcode, rs, rt, rd, shamt, funct, imm16, jaddr,
      input  reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch, jump,
      input  alu_op, id_illegal
   );

   modport slave (
      input  if_valid, if_instr, if_pc4, stall_in, flush, ex_mem_read, ex_rt,
      output if_stall, id_valid, id_pc4, opcode, rs, rt, rd, shamt, funct, imm16, jaddr,
      output reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch, jump,
      output alu_op, id_illegal
   );
endinterface

// File: rtl/id_decode_stage_main_control.sv
// Main control: combinational opcode to control-word map; zero latency, no state.
module main_control
   import mips_pkg::*;
(
   input  logic [5:0] opcode,
   output ctrl_t      ctrl,
   output logic       known
);

   always_comb begin
      ctrl  = CTRL_NONE;
      known = 1'b1;
      case (opcode)
         OP_RTYPE: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_OP_FUNCT;
         end
         OP_LW: begin
            ctrl.alu_src    = 1'b1;
            ctrl.mem_read   = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.alu_op     = ALU_OP_ADD;
         end
         OP_SW: begin
            ctrl.alu_src   = 1'b1;
            ctrl.mem_write = 1'b1;
            ctrl.alu_op    = ALU_OP_ADD;
         end
         OP_BEQ: begin
            ctrl.branch = 1'b1;
            ctrl.alu_op = ALU_OP_SUB;
         end
         OP_ADDI: begin
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_OP_ADD;
         end
         OP_J: ctrl.jump = 1'b1;
         default: known = 1'b0;
      endcase
   end

endmodule

// File: rtl/id_decode_stage.sv
// IF/ID register plus field/control decode; one cycle latency, holds on stall_in or load-use hazard.
// Load-use hazard detection is built only when ID_LOAD_USE_STALL_EN is defined; otherwise hazard is 0.
module id_decode_stage
   import mips_pkg::*;
#(
   parameter int unsigned ILLEGAL_TRAP = 0
) (
   input logic              clk,
   input logic              reset,
   id_decode_stage_if.slave bus
);

   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic        hazard;
   logic        bubble;
   ctrl_t       ctrl_raw;
   logic        op_known;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_q <= INSTR_NOP;
         pc4_q   <= 32'h0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   // Flush beats any hold; PC+4 is left alone because a bubble never uses it.
   always_comb begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (bus.flush) begin
         instr_d = INSTR_NOP;
         valid_d = 1'b0;
      end else if (!(bus.stall_in || hazard)) begin
         instr_d = bus.if_instr;
         pc4_d   = bus.if_pc4;
         valid_d = bus.if_valid;
      end
   end

`ifdef ID_LOAD_USE_STALL_EN
   logic uses_rt;
   always_comb begin
      uses_rt = (instr_q[31:26] == OP_RTYPE) || (instr_q[31:26] == OP_SW) ||
                (instr_q[31:26] == OP_BEQ);
      hazard  = bus.ex_mem_read && (bus.ex_rt != 5'd0) && valid_q &&
                ((bus.ex_rt == instr_q[25:21]) || (uses_rt && (bus.ex_rt == instr_q[20:16])));
   end
`else
   logic unused_ex;
   assign unused_ex = ^{bus.ex_mem_read, bus.ex_rt};
   assign hazard    = 1'b0;
`endif

   main_control u_main_control (
      .opcode (instr_q[31:26]),
      .ctrl   (ctrl_raw),
      .known  (op_known)
   );

   assign bubble = !valid_q || hazard;

   always_comb begin
      bus.reg_dst    = ctrl_raw.reg_dst    && !bubble;
      bus.alu_src    = ctrl_raw.alu_src    && !bubble;
      bus.mem_read   = ctrl_raw.mem_read   && !bubble;
      bus.mem_write  = ctrl_raw.mem_write  && !bubble;
      bus.mem_to_reg = ctrl_raw.mem_to_reg && !bubble;
      bus.reg_write  = ctrl_raw.reg_write  && !bubble;
      bus.branch     = ctrl_raw.branch     && !bubble;
      bus.jump       = ctrl_raw.jump       && !bubble;
      bus.alu_op     = bubble ? 2'b00 : ctrl_raw.alu_op;
      bus.id_illegal = (ILLEGAL_TRAP != 0) && !op_known && !bubble;
   end

   assign bus.if_stall = bus.stall_in || hazard;
   assign bus.id_valid = valid_q;
   assign bus.id_pc4   = pc4_q;
   assign bus.opcode   = instr_q[31:26];
   assign bus.rs       = instr_q[25:21];
   assign bus.rt       = instr_q[20:16];
   assign bus.rd       = instr_q[15:11];
   assign bus.shamt    = instr_q[10:6];
   assign bus.funct    = instr_q[5:0];
   assign bus.imm16    = instr_q[15:0];
   assign bus.jaddr    = instr_q[25:0];

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed vector bench for id_decode_stage, with a registered sign-extender modelled downstream.
module tb_id_decode_stage;

`ifdef ID_LOAD_USE_STALL_EN
   localparam bit HZ = 1'b1;
`else
   localparam bit HZ = 1'b0;
`endif

   localparam logic [9:0] C_NONE = 10'b0000000000;
   localparam logic [9:0] C_LW   = 10'b0110110000;
   localparam logic [9:0] C_ADDI = 10'b0100010000;
   localparam logic [9:0] C_R    = 10'b1000010010;
   localparam logic [9:0] C_SW   = 10'b0101000000;
   localparam logic [9:0] C_BEQ  = 10'b0000001001;
   localparam logic [9:0] C_J    = 10'b0000000100;

   localparam logic [31:0] I_LW   = 32'h8C88_0010;
   localparam logic [31:0] I_ADDI = 32'h2008_FEBD;
   localparam logic [31:0] I_ADD  = 32'h0022_1820;
   localparam logic [31:0] I_SW   = 32'hAC03_0004;
   localparam logic [31:0] I_BEQ  = 32'h1022_0003;
   localparam logic [31:0] I_J    = 32'h0800_0040;
   localparam logic [31:0] I_ILL  = 32'hFC00_0000;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        vld;
      logic        stall;
      logic        flush;
      logic        exmr;
      logic [4:0]  exrt;
      logic [31:0] e_instr;
      logic [31:0] e_pc4;
      logic        e_vld;
      logic [9:0]  e_ctrl;
      logic        e_ill;
      logic        e_stall;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] sext_q;
   int          checks = 0;
   int          failures = 0;
   vec_t        tv[14];

   always #5 clk = ~clk;

   id_decode_stage_if u_if ();
   id_decode_stage_if u_if0 ();

   assign u_if0.if_valid    = u_if.if_valid;
   assign u_if0.if_instr    = u_if.if_instr;
   assign u_if0.if_pc4      = u_if.if_pc4;
   assign u_if0.stall_in    = u_if.stall_in;
   assign u_if0.flush       = u_if.flush;
   assign u_if0.ex_mem_read = u_if.ex_mem_read;
   assign u_if0.ex_rt       = u_if.ex_rt;

   id_decode_stage #(.ILLEGAL_TRAP(1)) dut (.clk(clk), .reset(reset), .bus(u_if));
   id_decode_stage #(.ILLEGAL_TRAP(0)) dut0 (.clk(clk), .reset(reset), .bus(u_if0));

   // Downstream clocked sign-extender fed from imm16.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) sext_q <= 32'h0;
      else       sext_q <= {{16{u_if.imm16[15]}}, u_if.imm16};
   end

   function automatic logic [9:0] ctrl_now();
      return {u_if.reg_dst, u_if.alu_src, u_if.mem_read, u_if.mem_write, u_if.mem_to_reg,
              u_if.reg_write, u_if.branch, u_if.jump, u_if.alu_op};
   endfunction

   function automatic logic [31:0] instr_now();
      return {u_if.opcode, u_if.rs, u_if.rt, u_if.rd, u_if.shamt, u_if.funct};
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s [%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      u_if.if_instr    = v.instr;
      u_if.if_pc4      = v.pc4;
      u_if.if_valid    = v.vld;
      u_if.stall_in    = v.stall;
      u_if.flush       = v.flush;
      u_if.ex_mem_read = v.exmr;
      u_if.ex_rt       = v.exrt;
   endtask

   initial begin
      logic [31:0] prev_instr;
      logic [31:0] ei;
      vec_t        z;

      tv[0]  = '{I_LW,   32'h104, 1, 0, 0, 0, 5'd0, I_LW,   32'h104, 1, C_LW,   0, 0};
      tv[1]  = '{I_ADDI, 32'h108, 1, 0, 0, 0, 5'd0, I_ADDI, 32'h108, 1, C_ADDI, 0, 0};
      tv[2]  = '{I_ADD,  32'h10C, 1, 0, 0, 0, 5'd0, I_ADD,  32'h10C, 1, C_R,    0, 0};
      if (HZ) tv[3] = '{I_SW, 32'h110, 1, 0, 0, 1, 5'd1, I_ADD, 32'h10C, 1, C_NONE, 0, 1};
      else    tv[3] = '{I_SW, 32'h110, 1, 0, 0, 1, 5'd1, I_SW,  32'h110, 1, C_SW,   0, 0};
      tv[4]  = tv[3];
      tv[5]  = '{I_SW,   32'h110, 1, 0, 0, 0, 5'd1, I_SW,   32'h110, 1, C_SW,   0, 0};
      tv[6]  = '{I_BEQ,  32'h114, 1, 0, 0, 1, 5'd0, I_BEQ,  32'h114, 1, C_BEQ,  0, 0};
      if (HZ) tv[7] = '{I_J, 32'h118, 1, 0, 0, 1, 5'd2, I_BEQ, 32'h114, 1, C_NONE, 0, 1};
      else    tv[7] = '{I_J, 32'h118, 1, 0, 0, 1, 5'd2, I_J,   32'h118, 1, C_J,    0, 0};
      tv[8]  = '{I_J,    32'h118, 1, 1, 1, 1, 5'd2, 32'h0, HZ ? 32'h114 : 32'h118, 0, C_NONE, 0, 1};
      tv[9]  = '{I_ILL,  32'h11C, 1, 0, 0, 0, 5'd0, I_ILL,  32'h11C, 1, C_NONE, 1, 0};
      tv[10] = '{I_LW,   32'h120, 0, 0, 0, 0, 5'd0, I_LW,   32'h120, 0, C_NONE, 0, 0};
      tv[11] = '{I_ADDI, 32'h124, 1, 1, 0, 0, 5'd0, I_LW,   32'h120, 0, C_NONE, 0, 1};
      tv[12] = '{I_ADDI, 32'h128, 1, 0, 0, 1, 5'd8, I_ADDI, 32'h128, 1, C_ADDI, 0, 0};
      tv[13] = '{I_J,    32'h12C, 1, 0, 0, 0, 5'd0, I_J,    32'h12C, 1, C_J,    0, 0};

      z = '{32'h0, 32'h0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0, C_NONE, 0, 0};
      drive(z);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      chk("reset_valid", -1, {31'h0, u_if.id_valid}, 32'h0);
      chk("reset_pc4",   -1, u_if.id_pc4, 32'h0);
      chk("reset_instr", -1, instr_now(), 32'h0);
      chk("reset_ctrl",  -1, {22'h0, ctrl_now()}, {22'h0, C_NONE});
      chk("reset_stall", -1, {31'h0, u_if.if_stall}, 32'h0);

      prev_instr = 32'h0;
      for (int i = 0; i < 14; i++) begin
         drive(tv[i]);
         @(posedge clk);
         #1;
         ei = tv[i].e_instr;
         chk("fields",   i, instr_now(), ei);
         chk("imm16",    i, {16'h0, u_if.imm16}, {16'h0, ei[15:0]});
         chk("jaddr",    i, {6'h0, u_if.jaddr}, {6'h0, ei[25:0]});
         chk("id_pc4",   i, u_if.id_pc4, tv[i].e_pc4);
         chk("id_valid", i, {31'h0, u_if.id_valid}, {31'h0, tv[i].e_vld});
         chk("ctrl",     i, {22'h0, ctrl_now()}, {22'h0, tv[i].e_ctrl});
         chk("illegal",  i, {31'h0, u_if.id_illegal}, {31'h0, tv[i].e_ill});
         chk("illegal_notrap", i, {31'h0, u_if0.id_illegal}, 32'h0);
         chk("if_stall", i, {31'h0, u_if.if_stall}, {31'h0, tv[i].e_stall});
         chk("sext",     i, sext_q, {{16{prev_instr[15]}}, prev_instr[15:0]});
         prev_instr = ei;
      end

      // Asynchronous reset mid-cycle must clear the stage before any edge.
      #2 reset = 1'b1;
      #1;
      chk("async_valid", 100, {31'h0, u_if.id_valid}, 32'h0);
      chk("async_pc4",   100, u_if.id_pc4, 32'h0);
      chk("async_instr", 100, instr_now(), 32'h0);
      chk("async_ctrl",  100, {22'h0, ctrl_now()}, {22'h0, C_NONE});

      @(negedge clk);
      reset = 1'b0;
      z.instr = I_LW; z.pc4 = 32'h200; z.vld = 1'b1;
      drive(z);
      #1;
      chk("post_reset_idle", 101, {31'h0, u_if.id_valid}, 32'h0);
      @(posedge clk);
      #1;
      chk("first_load_instr", 102, instr_now(), I_LW);
      chk("first_load_pc4",   102, u_if.id_pc4, 32'h200);
      chk("first_load_ctrl",  102, {22'h0, ctrl_now()}, {22'h0, C_LW});
      chk("first_load_valid", 102, {31'h0, u_if.id_valid}, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/id_decode_stage.md
# id_decode_stage

IF/ID pipeline register plus instruction field decoder for the MIPS datapath. Latches the fetched instruction and PC+4 each cycle, splits it into register indices, immediate and jump fields, and produces the main control word. `imm16` feeds the 16-to-32 sign-extender directly downstream, which is itself clocked. An optional load-use hazard unit stalls fetch and inserts a bubble.

## Interface
Parameters:
- `ILLEGAL_TRAP`, default 0: when 1, an illegal opcode raises `id_illegal`. When 0, `id_illegal` is tied low.

Ports:
- `clk` in 1: single clock, posedge.
- `reset` in 1: asynchronous, active-high.
- `if_valid` in 1: fetch presents a valid instruction.
- `if_instr` in 32: fetched instruction word.
- `if_pc4` in 32: PC+4 of the fetched instruction.
- `stall_in` in 1: downstream hold. The stage keeps its contents.
- `flush` in 1: branch/jump taken. Squashes the held instruction.
- `ex_mem_read` in 1: instruction in EX is a load.
- `ex_rt` in 5: destination register of that load.
- `if_stall` out 1: tells fetch to hold PC and instruction.
- `id_valid` out 1: outputs carry a real instruction, not a bubble.
- `id_pc4` out 32: registered PC+4.
- `opcode` out 6, `rs` out 5, `rt` out 5, `rd` out 5, `shamt` out 5, `funct` out 6: instruction fields.
- `imm16` out 16: immediate field, sent to the sign-extender.
- `jaddr` out 26: jump target field.
- `reg_dst`, `alu_src`, `mem_read`, `mem_write`, `mem_to_reg`, `reg_write`, `branch`, `jump` out 1 each: control bits.
- `alu_op` out 2: ALU operation class.
- `id_illegal` out 1: unrecognised opcode.

## Operation
- Instruction register update priority on posedge: reset, then flush, then hold, then load.
  - Reset: instruction register = 0x00000000 (nop), `id_pc4` = 0, `id_valid` = 0.
  - Flush: `id_valid` ← 0 and instruction ← 0, regardless of any stall.
  - Hold: taken when `stall_in` or `hazard` is high. All registers keep their value.
  - Load: instruction ← `if_instr`, `id_pc4` ← `if_pc4`, `id_valid` ← `if_valid`.
- Field outputs are combinational slices of the registered instruction: [31:26], [25:21], [20:16], [15:11], [10:6], [5:0], [15:0], [25:0].
- Control decode, by opcode:
  - 0x00 (R-type): `reg_dst`, `reg_write`, `alu_op` = 10.
  - 0x23 (lw): `alu_src`, `mem_read`, `mem_to_reg`, `reg_write`, `alu_op` = 00.
  - 0x2B (sw): `alu_src`, `mem_write`, `alu_op` = 00.
  - 0x04 (beq): `branch`, `alu_op` = 01.
  - 0x08 (addi): `alu_src`, `reg_write`, `alu_op` = 00.
  - 0x02 (j): `jump`.
  - Any other opcode: all control bits 0; `id_illegal` = `ILLEGAL_TRAP && id_valid`.
- Bubble rule: while `id_valid` = 0 or `hazard` = 1, every control bit and `id_illegal` is forced to 0. Fields still show the register contents.
- `if_stall` = `stall_in | hazard`.

## Timing
- Latency: fetch presented in cycle N gives decoded outputs in N+1. The sign-extended immediate is ready in N+2, because the sign-extender registers.
- `hazard` is combinational within the same cycle. It drops once the load leaves EX (`ex_mem_read` falls).
- Reset asserted mid-stall clears the stage immediately, asynchronously. First load happens on the first posedge after `reset` falls.
- Simultaneous `flush` and hazard: the flush wins and clears `id_valid`. `hazard` then evaluates to 0.

## Configuration
- `ID_LOAD_USE_STALL_EN` defined: `hazard` is computed as follows.
  - Condition: `ex_mem_read && ex_rt != 0 && id_valid`.
  - And `ex_rt` matches either `rs`, or `rt` for R-type/sw/beq.
- Undefined: `hazard` is tied to 0. Load-use correctness then relies on software-inserted nops.

## Structure
- A shared package `mips_pkg` holds:
  - opcode constants: `OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_ADDI`, `OP_J`;
  - `ALU_OP_*` encodings;
  - the nop constant 0x00000000.
- One sub-module, `main_control`: combinational mapping from opcode to control bits. The stage owns the register, the bubble gating and the hazard logic.

## Test plan
- Reset then load `0x8C880010` (lw) → next cycle: `opcode` = 0x23, `rs` = 4, `rt` = 8, `imm16` = 0x0010, `mem_read` = `mem_to_reg` = `alu_src` = `reg_write` = 1, `id_valid` = 1.
- Load `0x2008FEBD` (addi $t0,$zero,-323) → `imm16` = 0xFEBD, `alu_src` = `reg_write` = 1. One cycle later the sign-extender output = 0xFFFFFEBD.
- Load `0x00221820` (add $3,$1,$2) → `rs` = 1, `rt` = 2, `rd` = 3, `funct` = 0x20, `reg_dst` = 1, `alu_op` = 10.
- Same add held with `ex_mem_read` = 1, `ex_rt` = 1 and the macro defined → `if_stall` = 1, control bits 0. The add stays held until `ex_mem_read` falls, then it issues.
- Assert `flush` together with `stall_in` → next cycle `id_valid` = 0, instruction = 0, all control bits 0.
- Opcode 0x3F with `ILLEGAL_TRAP` = 1 → `id_illegal` = 1 and all control bits 0. Asynchronous `reset` pulse mid-cycle → outputs cleared before the next clock edge.
